// File: rtl/sram_frame_writer.sv
// sram_frame_writer: buffers a pixel stream and writes it raster-order into the shared video SRAM in free bus slots
module sram_frame_writer #(
  parameter int FIFO_AW = 3,
  parameter int X_BITS  = 9,
  parameter int Y_BITS  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic        v_busy,
  input  logic        v_soon,
  output logic        wr_act,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n,
  output logic        busy,
  output logic        done
);
  localparam int AW = X_BITS + Y_BITS;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt;
  logic [AW-1:0] xy;
  logic last_f, push, go, fin;
  assign px_ready = busy & ~cnt[FIFO_AW];
  assign push = px_valid & px_ready;
  // a restart request takes priority over launching a new write in the same cycle
  assign go = (state == IDLE) & busy & (cnt != '0) & ~v_busy & ~v_soon & ~start;
  assign fin = (state == HOLD) & last_f & ~start;
  assign sram_oe_n = 1'b1;
  // one pass IDLE->SETUP->STROBE->HOLD->IDLE per word; the IDLE cycle is the bus turnaround
  always_comb begin
    state_n = go ? SETUP : state == SETUP ? STROBE : state == STROBE ? HOLD : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // FIFO pointers and occupancy; start and frame completion both flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (start) begin
      wp <= FIFO_AW'(push);
      rp <= '0;
      cnt <= (FIFO_AW+1)'(push);
    end else if (fin) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + FIFO_AW'(push);
      rp <= rp + FIFO_AW'(go);
      cnt <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(go);
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[start ? '0 : wp] <= px_data;
  end
  // frame position advances as each word is launched, so a restart never re-issues the in-flight address
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      xy <= '0;
      last_f <= 1'b0;
      wr_act <= 1'b0;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      busy <= start | (busy & ~fin);
      done <= fin;
      if (start) begin
        xy <= '0;
        last_f <= 1'b0;
      end else if (go) begin
        xy <= xy + AW'(1);
        last_f <= &xy;
      end
      if (go) begin
        sram_addr <= 18'(xy);
        sram_dq_o <= mem[rp];
      end
      wr_act <= state_n != IDLE;
      sram_dq_oe <= state_n != IDLE;
      sram_ce_n <= state_n == IDLE;
      sram_lb_n <= state_n == IDLE;
      sram_ub_n <= state_n == IDLE;
      sram_we_n <= state_n != STROBE;
    end
  end
endmodule

// File: tb/tb_sram_frame_writer.sv
// tb_sram_frame_writer: randomized stream against a word-level reference of the frame writer
module tb_sram_frame_writer;
  localparam int XB = 5;
  localparam int YB = 4;
  localparam int FRAME = 1 << (XB + YB);
  localparam int DEPTH = 8;

  logic clk = 0, rst = 1, start = 0, px_valid = 0, px_ready, wr_act;
  logic [15:0] px_data = 0, sram_dq_o;
  logic [17:0] sram_addr;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, busy, done;
  logic v_busy, v_soon;
  logic man_busy = 0, man_soon = 0, gen_busy = 0, gen_soon = 0, vid_en = 0;
  assign v_busy = man_busy | gen_busy;
  assign v_soon = man_soon | gen_soon;

  sram_frame_writer #(.FIFO_AW(3), .X_BITS(XB), .Y_BITS(YB)) dut (
    .clk(clk), .rst(rst), .start(start), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .v_busy(v_busy), .v_soon(v_soon), .wr_act(wr_act),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // source: drains src_val[src_i..src_lim-1], holding a word until it is accepted
  logic [15:0] src_val [0:4095];
  int src_i = 0, src_lim = 0;
  logic src_pause = 0, src_gap = 0;
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = px_valid && px_ready;
      if (acc) src_i++;
      @(posedge clk); #1;
      if (src_pause || src_i >= src_lim) px_valid = 0;
      else if (px_valid && !acc) px_valid = 1;
      else if (src_gap && $urandom_range(3) == 0) px_valid = 0;
      else begin
        px_valid = 1;
        px_data = src_val[src_i];
      end
    end
  end

  // video fetch: gap, then v_soon for exactly 4 cycles, then v_busy
  initial begin
    int vc, vph;
    vc = 1;
    vph = 0;
    forever begin
      @(posedge clk); #1;
      if (!vid_en) begin
        vph = 0;
        vc = 1;
        gen_soon = 0;
        gen_busy = 0;
      end else begin
        if (vc == 0) begin
          vph = (vph + 1) % 3;
          vc = vph == 1 ? 4 : vph == 2 ? int'($urandom_range(20, 8)) : int'($urandom_range(40, 5));
        end
        gen_soon = vph == 1;
        gen_busy = vph == 2;
        vc--;
      end
    end
  end

  // reference: queue of accepted words, frame index k, one 3-cycle write per launched word
  logic [15:0] q[$];
  int k = 0, phase = 0, fw = 0, n_log = 0, done_cnt = 0, cyc = 0;
  logic [17:0] log_addr [0:4095];
  logic [15:0] log_data [0:4095];
  int log_cyc [0:4095];
  logic [17:0] cur_a = 0, last_addr = 0;
  logic [15:0] cur_d = 0;
  bit busy_m = 0, done_exp = 0, inflight = 0, last_w = 0, cancel = 0, exp_go = 0, rst_p = 1, prev_wr = 0;
  initial begin
    bit rose, rdy;
    forever begin
      @(negedge clk);
      cyc++;
      rose = !prev_wr && wr_act;
      if (rst_p) begin
        busy_m = 0; q.delete(); k = 0; inflight = 0; done_exp = 0; fw = 0;
        chk("reset_addr", sram_addr, 0);
        chk("reset_dq", sram_dq_o, 0);
      end else begin
        done_exp = 0;
        if (prev_wr && !wr_act && inflight) begin
          chk("write_len", phase, 2);
          inflight = 0;
          if (last_w && !cancel) begin
            done_exp = 1;
            busy_m = 0;
            q.delete();
          end
        end
        chk("write_start", rose, exp_go);
        if (rose) begin
          cur_d = q.size() > 0 ? q.pop_front() : 16'hxxxx;
          cur_a = 18'(k);
          k = (k + 1) % FRAME;
          last_w = cur_a == 18'(FRAME - 1);
          cancel = 0;
          inflight = 1;
          phase = 0;
          fw++;
          last_addr = cur_a;
          if (n_log < 4096) begin
            log_addr[n_log] = sram_addr;
            log_data[n_log] = sram_dq_o;
            log_cyc[n_log] = cyc;
            n_log++;
          end
        end else if (inflight) phase++;
      end
      if (done) done_cnt++;
      chk("done", done, done_exp);
      chk("busy", busy, busy_m);
      chk("px_ready", px_ready, busy_m && q.size() < DEPTH);
      chk("oe_n", sram_oe_n, 1);
      chk("lb_ub_pair", sram_lb_n, sram_ub_n);
      chk("bus_clash", wr_act & v_busy, 0);
      chk("wr_act", wr_act, inflight);
      chk("ce_n", sram_ce_n, !inflight);
      chk("dq_oe", sram_dq_oe, inflight);
      chk("we_n", sram_we_n, !(inflight && phase == 1));
      if (inflight) begin
        chk("write_over", phase > 2, 0);
        chk("addr", sram_addr, cur_a);
        chk("data", sram_dq_o, cur_d);
      end
      prev_wr = wr_act;
      rst_p = rst;
      if (rst) exp_go = 0;
      else begin
        rdy = busy_m && q.size() < DEPTH;
        exp_go = busy_m && q.size() > 0 && !v_busy && !v_soon && !start && !wr_act;
        if (start) begin
          q.delete(); k = 0; busy_m = 1; cancel = inflight; fw = 0;
        end else if (px_valid && rdy) q.push_back(px_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) src_val[src_lim + i] = 16'($urandom);
    src_lim += n;
  endtask

  task automatic do_start();
    src_pause = 1;
    tick(); tick();
    src_lim = src_i;
    start = 1;
    tick();
    start = 0;
    src_pause = 0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 20000 && n_log < n; i++) tick();
    chk("wait_writes", n_log >= n, 1);
    repeat (4) tick();
  endtask

  task automatic wait_rise(input int want_fw);
    bit w0, ok;
    w0 = wr_act;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      tick();
      ok = wr_act && !w0 && (want_fw < 0 || fw == want_fw);
      w0 = wr_act;
    end
    chk("wait_write_start", ok, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b, nl, nw, d0, idx;
    logic [15:0] v0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", px_ready, 0);
    chk("rst_wr_act", wr_act, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_done", done, 0);

    // four words, free bus: addresses 0..3, four clocks apart
    do_start();
    nl = n_log;
    for (int i = 0; i < 4; i++) src_val[src_lim + i] = 16'h1111 * 16'(i + 1);
    src_lim += 4;
    wait_log(nl + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[nl + i], i);
      chk("t1_data", log_data[nl + i], 16'h1111 * 16'(i + 1));
      if (i > 0) chk("t1_spacing", log_cyc[nl + i] - log_cyc[nl + i - 1], 4);
    end

    // twelve words against a stalled bus: eight taken, ninth held
    man_busy = 1;
    tick();
    b = src_i;
    nl = n_log;
    for (int i = 0; i < 12; i++) src_val[src_lim + i] = 16'hA000 + 16'(i);
    src_lim += 12;
    repeat (20) tick();
    chk("t2_accepted", src_i - b, 8);
    chk("t2_ready_low", px_ready, 0);
    chk("t2_held_valid", px_valid, 1);
    chk("t2_held_word", px_data, 16'hA008);
    man_busy = 0;
    wait_log(nl + 12);
    for (int i = 0; i < 12; i++) begin
      chk("t2_data", log_data[nl + i], 16'hA000 + 16'(i));
      chk("t2_addr", log_addr[nl + i], 4 + i);
    end

    // v_soon raised during SETUP: the write completes, nothing new until the bus is clear
    nl = n_log;
    fill(12);
    wait_rise(-1);
    man_soon = 1;
    nw = n_log + 1;
    repeat (4) tick();
    man_soon = 0;
    man_busy = 1;
    repeat (8) tick();
    chk("t3_no_new_write", n_log, nw);
    man_busy = 0;
    wait_log(nl + 12);

    // full frame with random video fetch traffic
    do_start();
    vid_en = 1;
    src_gap = 1;
    d0 = done_cnt;
    fill(FRAME + 3);
    for (int i = 0; i < 40000 && done_cnt == d0; i++) tick();
    repeat (10) tick();
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_words", fw, FRAME);
    chk("t4_last_addr", last_addr, 18'h1FF);
    chk("t4_busy", busy, 0);
    chk("t4_ready", px_ready, 0);
    vid_en = 0;

    // reset in STROBE releases the bus on the next cycle
    do_start();
    fill(6);
    wait_rise(-1);
    tick();
    chk("t5_strobe", sram_we_n, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_we_n", sram_we_n, 1);
    chk("t5_ce_n", sram_ce_n, 1);
    chk("t5_dq_oe", sram_dq_oe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", px_ready, 0);
    chk("t5_wr_act", wr_act, 0);

    // restart while word 100 is on the bus
    do_start();
    fill(150);
    wait_rise(100);
    chk("t6_addr100", sram_addr, 100);
    idx = n_log;
    src_pause = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    src_lim = src_i;
    v0 = 16'h5A5A;
    src_val[src_lim] = v0;
    src_lim++;
    fill(7);
    src_pause = 0;
    wait_log(idx + 9);
    chk("t6_inflight_addr", log_addr[idx], 100);
    chk("t6_restart_addr", log_addr[idx + 1], 0);
    chk("t6_restart_data", log_data[idx + 1], 16'h5A5A);
    chk("t6_next_addr", log_addr[idx + 2], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
